// File: rtl/uart_rx_fifo.sv
// UART receiver with majority-vote sampling, 5-8 data bits, parity, 1/2 stop bits and a show-ahead FIFO.
// Push lands at mid last stop bit; rd_data is combinational from the head; UART_RX_TIMEOUT_EN adds an idle timeout.
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16,
  parameter int BAUD_W     = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [BAUD_W-1:0]               baud_div,
  input  logic [1:0]                      data_bits,
  input  logic                            parity_en,
  input  logic                            parity_odd0_even1,
  input  logic                            two_stop,
  input  logic                            rx_en,
  input  logic                            RX,
  input  logic                            rd_en,
  output logic [7:0]                      rd_data,
  output logic                            rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  input  logic [$clog2(FIFO_DEPTH):0]     rx_thresh,
  output logic                            rx_int,
  output logic                            parity_err,
  output logic                            frame_err,
  output logic                            overflow,
  input  logic                            err_clr,
  output logic                            rx_timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t            state, state_n;
  logic              rx_s1, rx_s2, rx_d;
  logic [BAUD_W-1:0] cnt;
  logic [SW-1:0]     samp_cnt;
  logic              s0, s1;
  logic [7:0]        shreg;
  logic [2:0]        bit_cnt;
  logic              char_perr, char_ferr;
  logic              push;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [LW-1:0]     level;

  logic fall, tick, tick_run, decide, bit_end, vote, start_go;
  logic do_pop, do_push, full, exp_par;
  logic [2:0] last_bit;

  assign fall     = rx_d & ~rx_s2;
  assign tick     = tick_run && (cnt == '0);
  assign decide   = tick && (samp_cnt == SW'(OVERSAMPLE/2 + 1));
  assign bit_end  = tick && (samp_cnt == SW'(OVERSAMPLE - 1));
  assign vote     = (s0 & s1) | (s0 & rx_s2) | (s1 & rx_s2);
  assign start_go = (state == IDLE) && (state_n == START);
  assign last_bit = {1'b0, data_bits} + 3'd4;
  assign exp_par  = (^shreg) ^ ~parity_odd0_even1;

`ifdef UART_RX_TIMEOUT_EN
  assign tick_run = (state != IDLE) || (level != '0);
`else
  assign tick_run = (state != IDLE);
`endif

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    push    = 1'b0;
    case (state)
      IDLE:   if (rx_en && fall) state_n = START;
      START:  if (decide && vote) state_n = IDLE;
              else if (bit_end)   state_n = DATA;
      DATA:   if (bit_end && bit_cnt == last_bit)
                state_n = parity_en ? PARITY : STOP1;
      PARITY: if (bit_end) state_n = STOP1;
      STOP1:  if (decide && !two_stop) begin
                push    = 1'b1;
                state_n = IDLE;
              end else if (bit_end) begin
                state_n = STOP2;
              end
      STOP2:  if (decide) begin
                push    = 1'b1;
                state_n = IDLE;
              end
      default: state_n = IDLE;
    endcase
    if (!rx_en) begin
      state_n = IDLE;
      push    = 1'b0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_d      <= 1'b1;
      cnt       <= '0;
      samp_cnt  <= '0;
      s0        <= 1'b1;
      s1        <= 1'b1;
      shreg     <= '0;
      bit_cnt   <= '0;
      char_perr <= 1'b0;
      char_ferr <= 1'b0;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
      // The start edge realigns the bit clock to the incoming frame.
      if (start_go) begin
        cnt      <= baud_div;
        samp_cnt <= '0;
      end else if (tick_run) begin
        if (cnt == '0) begin
          cnt      <= baud_div;
          samp_cnt <= (samp_cnt == SW'(OVERSAMPLE - 1)) ? '0 : samp_cnt + 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
      if (tick && samp_cnt == SW'(OVERSAMPLE/2 - 1)) s0 <= rx_s2;
      if (tick && samp_cnt == SW'(OVERSAMPLE/2))     s1 <= rx_s2;
      if (start_go) begin
        shreg     <= '0;
        bit_cnt   <= '0;
        char_perr <= 1'b0;
        char_ferr <= 1'b0;
      end else begin
        if (state == DATA && decide)  shreg[bit_cnt] <= vote;
        if (state == DATA && bit_end) bit_cnt <= bit_cnt + 1'b1;
        if (state == PARITY && decide) char_perr <= (vote != exp_par);
        if (state == STOP1 && decide && !vote) char_ferr <= 1'b1;
      end
    end
  end

  assign do_pop  = rd_en && (level != '0);
  assign full    = (level == LW'(FIFO_DEPTH));
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge ACLK) begin
    if (do_push) mem[wptr] <= shreg;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Flag sets take priority over a simultaneous clear so no event is lost.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push && char_perr)              parity_err <= 1'b1;
      else if (err_clr)                   parity_err <= 1'b0;
      if (push && (char_ferr || !vote))   frame_err  <= 1'b1;
      else if (err_clr)                   frame_err  <= 1'b0;
      if (push && full && !do_pop)        overflow   <= 1'b1;
      else if (err_clr)                   overflow   <= 1'b0;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int LIMIT = 40 * OVERSAMPLE;
  localparam int TW    = $clog2(LIMIT + 1);
  logic [TW-1:0] idle_cnt;
  logic          to_hit;

  assign to_hit = tick && (state == IDLE) && (level != '0) && !do_pop &&
                  (idle_cnt == TW'(LIMIT - 1));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      idle_cnt   <= '0;
      rx_timeout <= 1'b0;
    end else begin
      if (do_push || do_pop || level == '0)
        idle_cnt <= '0;
      else if (tick && state == IDLE && idle_cnt != TW'(LIMIT))
        idle_cnt <= idle_cnt + 1'b1;
      if (to_hit)                 rx_timeout <= 1'b1;
      else if (do_pop || err_clr) rx_timeout <= 1'b0;
    end
  end
`else
  assign rx_timeout = 1'b0;
`endif

  assign fifo_level = level;
  assign rd_valid   = (level != '0);
  assign rd_data    = rd_valid ? mem[rptr] : 8'h00;
  assign rx_int     = ((level >= rx_thresh) && (rx_thresh != '0)) || overflow || rx_timeout;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: 8N1, 7E2 errors, false start, overflow, full push+pop, rx_en abort, timeout.
module tb_uart_rx_fifo;
  localparam int BIT_CYC = 64;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [15:0] baud_div;
  logic [1:0]  data_bits;
  logic        parity_en, parity_odd0_even1, two_stop, rx_en, RX, rd_en, err_clr;
  logic [4:0]  rx_thresh;
  logic [7:0]  rd_data;
  logic        rd_valid, rx_int, parity_err, frame_err, overflow, rx_timeout;
  logic [4:0]  fifo_level;

  int checks = 0;
  int failures = 0;

  always #5 ACLK = ~ACLK;

  uart_rx_fifo #(.FIFO_DEPTH(16), .OVERSAMPLE(16), .BAUD_W(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .baud_div(baud_div), .data_bits(data_bits),
    .parity_en(parity_en), .parity_odd0_even1(parity_odd0_even1), .two_stop(two_stop),
    .rx_en(rx_en), .RX(RX), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_level(fifo_level), .rx_thresh(rx_thresh), .rx_int(rx_int),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow),
    .err_clr(err_clr), .rx_timeout(rx_timeout)
  );

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic par_on,
                            input logic par_bit, input logic st2_on, input logic st2_val);
    RX = 1'b0;
    repeat (BIT_CYC) @(negedge ACLK);
    for (int i = 0; i < nbits; i++) begin
      RX = d[i];
      repeat (BIT_CYC) @(negedge ACLK);
    end
    if (par_on) begin
      RX = par_bit;
      repeat (BIT_CYC) @(negedge ACLK);
    end
    RX = 1'b1;
    repeat (BIT_CYC) @(negedge ACLK);
    if (st2_on) begin
      RX = st2_val;
      repeat (BIT_CYC) @(negedge ACLK);
    end
    RX = 1'b1;
    repeat (BIT_CYC) @(negedge ACLK);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    @(negedge ACLK);
    rd_en = 1'b0;
    @(negedge ACLK);
  endtask

  task automatic set_8n1();
    data_bits = 2'b11; parity_en = 1'b0; parity_odd0_even1 = 1'b0; two_stop = 1'b0;
  endtask

  task automatic test_reset();
    ARESET = 1'b1; baud_div = 16'd3; rx_en = 1'b1; RX = 1'b1; rd_en = 1'b0;
    err_clr = 1'b0; rx_thresh = 5'd0;
    set_8n1();
    repeat (4) @(negedge ACLK);
    checks++;
    if ({rd_valid, rx_int, parity_err, frame_err, overflow, rx_timeout} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 000000",
               {rd_valid, rx_int, parity_err, frame_err, overflow, rx_timeout});
    end
    ARESET = 1'b0;
    repeat (4) @(negedge ACLK);
    checks++;
    if (fifo_level !== 5'd0 || rd_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_fifo: got level=%0d data=%h expected level=0 data=00", fifo_level, rd_data);
    end
  endtask

  task automatic test_8n1();
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || fifo_level !== 5'd1) begin
      failures++;
      $display("FAIL 8n1_data: got valid=%b data=%h level=%0d expected 1 a5 1", rd_valid, rd_data, fifo_level);
    end
    checks++;
    if ({parity_err, frame_err, overflow} !== 3'b000) begin
      failures++;
      $display("FAIL 8n1_flags: got %b expected 000", {parity_err, frame_err, overflow});
    end
    rx_thresh = 5'd1;
    @(negedge ACLK);
    checks++;
    if (rx_int !== 1'b1) begin
      failures++;
      $display("FAIL thresh_hit: got rx_int=%b expected 1", rx_int);
    end
    rx_thresh = 5'd2;
    @(negedge ACLK);
    checks++;
    if (rx_int !== 1'b0) begin
      failures++;
      $display("FAIL thresh_miss: got rx_int=%b expected 0", rx_int);
    end
    rx_thresh = 5'd0;
    pop_one();
    checks++;
    if (rd_valid !== 1'b0 || fifo_level !== 5'd0) begin
      failures++;
      $display("FAIL 8n1_pop: got valid=%b level=%0d expected 0 0", rd_valid, fifo_level);
    end
  endtask

  task automatic test_7e2_errors();
    data_bits = 2'b10; parity_en = 1'b1; parity_odd0_even1 = 1'b1; two_stop = 1'b1;
    // 0x35 has four ones over 7 bits, so correct even parity is 0; send 1.
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (parity_err !== 1'b1 || frame_err !== 1'b0 || rd_data !== 8'h35) begin
      failures++;
      $display("FAIL 7e2_parity: got perr=%b ferr=%b data=%h expected 1 0 35", parity_err, frame_err, rd_data);
    end
    send_frame(8'h12, 7, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (frame_err !== 1'b1 || parity_err !== 1'b1 || fifo_level !== 5'd2 || rd_data !== 8'h35) begin
      failures++;
      $display("FAIL 7e2_frame: got ferr=%b perr=%b level=%0d head=%h expected 1 1 2 35",
               frame_err, parity_err, fifo_level, rd_data);
    end
    pop_one();
    checks++;
    if (rd_data !== 8'h12) begin
      failures++;
      $display("FAIL 7e2_second: got %h expected 12", rd_data);
    end
    pop_one();
    err_clr = 1'b1;
    @(negedge ACLK);
    err_clr = 1'b0;
    @(negedge ACLK);
    checks++;
    if ({parity_err, frame_err, fifo_level} !== 7'd0) begin
      failures++;
      $display("FAIL err_clr: got perr=%b ferr=%b level=%0d expected 0 0 0", parity_err, frame_err, fifo_level);
    end
    set_8n1();
  endtask

  task automatic test_false_start();
    RX = 1'b0;
    repeat (12) @(negedge ACLK);
    RX = 1'b1;
    repeat (2 * BIT_CYC) @(negedge ACLK);
    checks++;
    if (fifo_level !== 5'd0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL false_start: got level=%0d valid=%b expected 0 0", fifo_level, rd_valid);
    end
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (fifo_level !== 5'd1 || rd_data !== 8'h3C) begin
      failures++;
      $display("FAIL after_false_start: got level=%0d data=%h expected 1 3c", fifo_level, rd_data);
    end
    pop_one();
  endtask

  task automatic test_overflow();
    logic [7:0] exp;
    for (int i = 0; i < 17; i++) send_frame(8'(i), 8, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (fifo_level !== 5'd16 || overflow !== 1'b1 || rd_data !== 8'h00 || rx_int !== 1'b1) begin
      failures++;
      $display("FAIL overflow: got level=%0d ovf=%b head=%h int=%b expected 16 1 00 1",
               fifo_level, overflow, rd_data, rx_int);
    end
    err_clr = 1'b1;
    @(negedge ACLK);
    err_clr = 1'b0;
    rx_thresh = 5'd16;
    @(negedge ACLK);
    checks++;
    if (overflow !== 1'b0 || rx_int !== 1'b1) begin
      failures++;
      $display("FAIL full_thresh: got ovf=%b int=%b expected 0 1", overflow, rx_int);
    end
    rx_thresh = 5'd0;
    @(negedge ACLK);
    checks++;
    if (rx_int !== 1'b0) begin
      failures++;
      $display("FAIL thresh_zero: got rx_int=%b expected 0", rx_int);
    end
    // Pop lines up with the push cycle: mid-point of the stop bit, 618 cycles after start.
    fork
      send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0);
      begin
        repeat (618) @(negedge ACLK);
        rd_en = 1'b1;
        @(negedge ACLK);
        rd_en = 1'b0;
      end
    join
    checks++;
    if (fifo_level !== 5'd16 || overflow !== 1'b0 || rd_data !== 8'h01) begin
      failures++;
      $display("FAIL full_push_pop: got level=%0d ovf=%b head=%h expected 16 0 01", fifo_level, overflow, rd_data);
    end
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? 8'(i + 1) : 8'h55;
      checks++;
      if (rd_data !== exp) begin
        failures++;
        $display("FAIL drain_%0d: got %h expected %h", i, rd_data, exp);
      end
      pop_one();
    end
    pop_one();
    checks++;
    if (fifo_level !== 5'd0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      failures++;
      $display("FAIL empty_pop: got level=%0d valid=%b data=%h expected 0 0 00", fifo_level, rd_valid, rd_data);
    end
  endtask

  task automatic test_rx_en_abort();
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    fork
      send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b0);
      begin
        repeat (3 * BIT_CYC) @(negedge ACLK);
        rx_en = 1'b0;
      end
    join
    rx_en = 1'b1;
    repeat (BIT_CYC) @(negedge ACLK);
    checks++;
    if (fifo_level !== 5'd1 || rd_data !== 8'h5A) begin
      failures++;
      $display("FAIL rx_en_abort: got level=%0d head=%h expected 1 5a", fifo_level, rd_data);
    end
    pop_one();
  endtask

  task automatic test_timeout();
    bit seen;
    send_frame(8'h77, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (rx_timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early: got %b expected 0", rx_timeout);
    end
    repeat (2300) @(negedge ACLK);
`ifdef UART_RX_TIMEOUT_EN
    checks++;
    if (rx_timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_before_limit: got %b expected 0", rx_timeout);
    end
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge ACLK);
      seen = rx_timeout;
    end
    checks++;
    if (rx_timeout !== 1'b1 || rx_int !== 1'b1) begin
      failures++;
      $display("FAIL timeout_set: got to=%b int=%b expected 1 1", rx_timeout, rx_int);
    end
    pop_one();
    checks++;
    if (rx_timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear: got %b expected 0", rx_timeout);
    end
`else
    seen = 1'b0;
    repeat (500) @(negedge ACLK);
    checks++;
    if (rx_timeout !== 1'b0 || rx_int !== 1'b0 || seen) begin
      failures++;
      $display("FAIL timeout_off: got to=%b int=%b expected 0 0", rx_timeout, rx_int);
    end
    pop_one();
`endif
  endtask

  initial begin
    @(negedge ACLK);
    test_reset();
    test_8n1();
    test_7e2_errors();
    test_false_start();
    test_overflow();
    test_rx_en_abort();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver, successor to the single-byte rx path of the AXI4-lite UART. Adds programmable oversampling, majority-vote bit sampling, 5–8 data bits, optional 2 stop bits, framing error and a show-ahead receive FIFO with threshold interrupt. Sits between the RX pin and the register block, which drives config and pops the FIFO.

Parameters:
FIFO_DEPTH, 16, receive FIFO entries; power of 2, at least 2.
OVERSAMPLE, 16, sample ticks per bit; even, at least 8.
BAUD_W, 16, width of baud_div.

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous active-high reset
baud_div  in  BAUD_W  sample tick period minus 1, in ACLK cycles
data_bits  in  2  00=5, 01=6, 10=7, 11=8 data bits
parity_en  in  1  parity bit expected
parity_odd0_even1  in  1  parity sense
two_stop  in  1  check 2 stop bits
rx_en  in  1  receiver enable
RX  in  1  asynchronous serial input
rd_en  in  1  pop FIFO head
rd_data  out  8  FIFO head, zero-extended for fewer than 8 data bits
rd_valid  out  1  FIFO not empty
fifo_level  out  log2(FIFO_DEPTH)+1  entry count
rx_thresh  in  log2(FIFO_DEPTH)+1  interrupt threshold
rx_int  out  1  interrupt request
parity_err  out  1  sticky flag
frame_err  out  1  sticky flag
overflow  out  1  sticky flag
err_clr  in  1  clear all sticky flags
rx_timeout  out  1  idle-timeout flag

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE. The RX synchroniser resets to 1.
- Synchronise RX through 2 flops.
- Tick counter: reloads from baud_div and pulses tick once every baud_div+1 cycles. It runs only while state is not IDLE, and restarts at the start edge. A bit lasts OVERSAMPLE ticks.
- Bit value is the majority of samples taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within the bit.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE -> START on a falling edge of synced RX while rx_en=1.
  - START: majority value 1 is a false start -> IDLE, nothing pushed. Value 0 -> DATA after the bit ends.
  - DATA: bits received LSB first. After data_bits+5 bits -> PARITY if parity_en, else STOP1.
  - PARITY: received bit compared with the expected bit (XOR of data, inverted for odd). Mismatch marks the character as a parity error.
  - STOP1: value 0 marks the character as a frame error. -> STOP2 if two_stop, else push.
  - STOP2: same stop-bit check, then push.
  - Push happens at the mid-bit decision of the last stop bit. FSM returns to IDLE at that point, so a back-to-back start edge is caught.
- On push: the character is written, and parity_err / frame_err are set when the character carried that error (error characters are still stored).
- FIFO full at push with no pop in the same cycle: character discarded, overflow set.
- Push and pop in the same cycle when full: both take effect, level unchanged, no overflow.
- rd_en while empty: ignored. rd_data is valid combinationally from the head; a pop advances it next cycle.
- fifo_level is exact, 0..FIFO_DEPTH. Read and write pointers wrap modulo FIFO_DEPTH.
- rx_int = (fifo_level >= rx_thresh and rx_thresh != 0) OR overflow OR rx_timeout.
- err_clr clears the sticky flags. A set in the same cycle as err_clr wins.
- rx_en deasserted mid-frame: FSM goes to IDLE next cycle, partial character dropped, FIFO contents kept.
- baud_div change mid-frame: takes effect at the next tick reload; frame integrity is not guaranteed.

Optional Feature:
UART_RX_TIMEOUT_EN
- Defined: idle counter in ticks. It clears on any push, on any pop, or when the FIFO is empty. rx_timeout sets when the FIFO is not empty, state is IDLE, and the counter reaches 4*10*OVERSAMPLE ticks. rx_timeout clears on the next pop or on err_clr.
- Tick generation continues in IDLE only while the FIFO is not empty.
- Not defined: rx_timeout tied to 0, no counter logic.

Test Plan:
- baud_div=3, 8N1, send 0xA5 -> after about 10*64 cycles rd_valid=1, rd_data=0xA5, fifo_level=1, no error flags.
- 7E2 (data_bits=10, parity_en=1, parity_odd0_even1=1, two_stop=1), send 0x35 with wrong parity, then a frame with second stop bit=0 -> two entries, 0x35 stored first; parity_err=1, then frame_err=1; err_clr -> both flags 0.
- RX low pulse of 3 ticks, then high -> false start, fifo_level stays 0, FSM back to IDLE.
- FIFO_DEPTH=16: send 17 bytes 0x00..0x10 with no reads -> fifo_level=16, overflow=1, head=0x00. Pop 16 -> last byte read is 0x0F.
- Level 16 (full), rd_en asserted in the push cycle of the next byte -> level stays 16, overflow unchanged, new byte stored.
- UART_RX_TIMEOUT_EN defined, OVERSAMPLE=16: one byte received, then idle 640 ticks -> rx_timeout=1 and rx_int=1; rd_en -> rx_timeout=0.
